// File: rtl/vtx_pkg.sv
// rtl/vtx_pkg.sv - shared types for vtx_txn_capture (FIFO entry carries CPRs when VTX_CPR_SNAPSHOT_EN)
package vtx_pkg;

    localparam int VTX_XLEN  = 32;
    localparam int VTX_NREGS = 16;

    localparam logic [2:0] VTX_RESULT_OK   = 3'd0;
    localparam logic [2:0] VTX_RESULT_FAIL = 3'd1;

    typedef struct packed {
`ifdef VTX_CPR_SNAPSHOT_EN
        logic [VTX_NREGS*VTX_XLEN-1:0] cprs;
`endif
        logic [31:0]         enc;
        logic [VTX_XLEN-1:0] rs1;
    } vtx_fifo_entry_t;

    typedef struct packed {
        logic [VTX_XLEN-1:0] addr;
        logic [VTX_XLEN-1:0] rdata;
        logic                wen;
        logic                error;
    } vtx_mem_entry_t;

endpackage

// File: rtl/vtx_inorder_fifo.sv
// rtl/vtx_inorder_fifo.sv - in-order FIFO; a push on full is taken only alongside a pop
module vtx_inorder_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       g_clk,
    input  logic                       g_reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr];

    always_ff @(posedge g_clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vtx_txn_capture.sv
// rtl/vtx_txn_capture.sv - multi-instruction COP transaction capture for the formal checkers
// Optional CPR pre/post snapshot ports under VTX_CPR_SNAPSHOT_EN.
module vtx_txn_capture
    import vtx_pkg::*;
#(
    parameter int XLEN     = VTX_XLEN,
    parameter int NREGS    = VTX_NREGS,
    parameter int DEPTH    = 4,
    parameter int MEM_HIST = 5
) (
    input  logic                          g_clk,
    input  logic                          g_reset,
    input  logic                          cpu_insn_req,
    input  logic                          cop_insn_ack,
    input  logic [31:0]                   cpu_insn_enc,
    input  logic [XLEN-1:0]               cpu_rs1,
    input  logic                          cop_insn_rsp,
    input  logic                          cpu_insn_ack,
    input  logic [2:0]                    cop_result,
    input  logic                          cop_wen,
    input  logic [4:0]                    cop_waddr,
    input  logic [XLEN-1:0]               cop_wdata,
    input  logic                          cop_mem_cen,
    input  logic                          cop_mem_wen,
    input  logic                          cop_mem_stall,
    input  logic                          cop_mem_error,
    input  logic [XLEN-1:0]               cop_mem_addr,
    input  logic [XLEN-1:0]               cop_mem_rdata,
    input  logic [NREGS*XLEN-1:0]         cprs_snoop,
    output logic                          vtx_valid,
    output logic [31:0]                   vtx_instr_enc,
    output logic [XLEN-1:0]               vtx_instr_rs1,
    output logic [2:0]                    vtx_instr_result,
    output logic                          vtx_instr_wen,
    output logic [4:0]                    vtx_instr_waddr,
    output logic [XLEN-1:0]               vtx_instr_wdata,
    output logic [$clog2(MEM_HIST+1)-1:0] vtx_mem_count,
    output logic [MEM_HIST*XLEN-1:0]      vtx_mem_addr,
    output logic [MEM_HIST*XLEN-1:0]      vtx_mem_rdata,
    output logic [MEM_HIST-1:0]           vtx_mem_wen,
    output logic [MEM_HIST-1:0]           vtx_mem_error,
    output logic [$clog2(DEPTH+1)-1:0]    vtx_inflight,
    output logic                          vtx_overflow,
    output logic                          vtx_underflow
`ifdef VTX_CPR_SNAPSHOT_EN
    ,
    output logic [NREGS*XLEN-1:0]         vtx_cprs_pre,
    output logic [NREGS*XLEN-1:0]         vtx_cprs_post
`endif
);

    localparam int CW = $clog2(MEM_HIST+1);

    logic            issue;
    logic            retire;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    vtx_fifo_entry_t push_entry;
    vtx_fifo_entry_t head;

    logic            p_mem_cen;
    logic            mem_start;
    logic            mem_finish;
    logic [CW-1:0]   mem_cnt;
    logic [CW-1:0]   mem_cnt_inc;
    vtx_mem_entry_t  hist     [MEM_HIST];
    vtx_mem_entry_t  hist_fin [MEM_HIST];
    vtx_mem_entry_t  hist_nxt [MEM_HIST];

    assign issue  = cpu_insn_req && cop_insn_ack;
    assign retire = cop_insn_rsp && cpu_insn_ack;
    assign pop    = retire && !fifo_empty;

    always_comb begin
        push_entry     = '0;
        push_entry.enc = cpu_insn_enc;
        push_entry.rs1 = cpu_rs1;
`ifdef VTX_CPR_SNAPSHOT_EN
        push_entry.cprs = cprs_snoop;
`endif
    end

`ifndef VTX_CPR_SNAPSHOT_EN
    logic unused_cprs;
    assign unused_cprs = ^cprs_snoop;
`endif

    vtx_inorder_fifo #(
        .W     ($bits(vtx_fifo_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .g_clk   (g_clk),
        .g_reset (g_reset),
        .push    (issue),
        .pop     (retire),
        .wdata   (push_entry),
        .rdata   (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (vtx_inflight)
    );

    assign mem_start   = !cop_mem_error && cop_mem_cen && (!p_mem_cen || !cop_mem_stall);
    assign mem_finish  = p_mem_cen && !cop_mem_stall;
    assign mem_cnt_inc = (mem_cnt == CW'(MEM_HIST)) ? mem_cnt : mem_cnt + 1'b1;

    // A finish completes the transaction currently in entry 0, so it is applied
    // before a same-cycle start shifts the history; snapshots see hist_fin.
    always_comb begin
        for (int i = 0; i < MEM_HIST; i++) hist_fin[i] = hist[i];
        if (mem_finish) begin
            hist_fin[0].rdata = cop_mem_rdata;
            hist_fin[0].error = cop_mem_error;
        end
        for (int i = 0; i < MEM_HIST; i++) hist_nxt[i] = hist_fin[i];
        if (mem_start) begin
            for (int i = 1; i < MEM_HIST; i++) hist_nxt[i] = hist_fin[i-1];
            hist_nxt[0].addr  = cop_mem_addr;
            hist_nxt[0].rdata = '0;
            hist_nxt[0].wen   = cop_mem_wen;
            hist_nxt[0].error = 1'b0;
        end
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            p_mem_cen        <= 1'b0;
            mem_cnt          <= '0;
            for (int i = 0; i < MEM_HIST; i++) hist[i] <= '0;
            vtx_valid        <= 1'b0;
            vtx_instr_enc    <= '0;
            vtx_instr_rs1    <= '0;
            vtx_instr_result <= '0;
            vtx_instr_wen    <= 1'b0;
            vtx_instr_waddr  <= '0;
            vtx_instr_wdata  <= '0;
            vtx_mem_count    <= '0;
            vtx_mem_addr     <= '0;
            vtx_mem_rdata    <= '0;
            vtx_mem_wen      <= '0;
            vtx_mem_error    <= '0;
            vtx_overflow     <= 1'b0;
            vtx_underflow    <= 1'b0;
`ifdef VTX_CPR_SNAPSHOT_EN
            vtx_cprs_pre     <= '0;
            vtx_cprs_post    <= '0;
`endif
        end else begin
            p_mem_cen <= cop_mem_cen;
            for (int i = 0; i < MEM_HIST; i++) hist[i] <= hist_nxt[i];
            // A start in the retire cycle belongs to the next instruction.
            if (pop) begin
                mem_cnt <= mem_start ? CW'(1) : '0;
            end else if (mem_start) begin
                mem_cnt <= mem_cnt_inc;
            end
            vtx_valid <= pop;
            if (pop) begin
                vtx_instr_enc    <= head.enc;
                vtx_instr_rs1    <= head.rs1;
                vtx_instr_result <= cop_result;
                vtx_instr_wen    <= cop_wen;
                vtx_instr_waddr  <= cop_waddr;
                vtx_instr_wdata  <= cop_wdata;
                vtx_mem_count    <= mem_cnt;
                for (int i = 0; i < MEM_HIST; i++) begin
                    vtx_mem_addr[i*XLEN +: XLEN]  <= hist_fin[i].addr;
                    vtx_mem_rdata[i*XLEN +: XLEN] <= hist_fin[i].rdata;
                    vtx_mem_wen[i]                <= hist_fin[i].wen;
                    vtx_mem_error[i]              <= hist_fin[i].error;
                end
`ifdef VTX_CPR_SNAPSHOT_EN
                vtx_cprs_pre  <= head.cprs;
                vtx_cprs_post <= cprs_snoop;
`endif
            end
            if (issue && fifo_full && !retire) vtx_overflow  <= 1'b1;
            if (retire && fifo_empty)          vtx_underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vtx_txn_capture.sv
// tb/tb_vtx_txn_capture.sv - directed table-driven bench for vtx_txn_capture (VTX_CPR_SNAPSHOT_EN adds a CPR case)
module tb_vtx_txn_capture;
    import vtx_pkg::*;

    localparam int XLEN     = 32;
    localparam int NREGS    = 16;
    localparam int DEPTH    = 4;
    localparam int MEM_HIST = 5;

    logic                    g_clk;
    logic                    g_reset;
    logic                    cpu_insn_req, cop_insn_ack, cop_insn_rsp, cpu_insn_ack;
    logic [31:0]             cpu_insn_enc;
    logic [XLEN-1:0]         cpu_rs1;
    logic [2:0]              cop_result;
    logic                    cop_wen;
    logic [4:0]              cop_waddr;
    logic [XLEN-1:0]         cop_wdata;
    logic                    cop_mem_cen, cop_mem_wen, cop_mem_stall, cop_mem_error;
    logic [XLEN-1:0]         cop_mem_addr, cop_mem_rdata;
    logic [NREGS*XLEN-1:0]   cprs_snoop;
    logic                    vtx_valid;
    logic [31:0]             vtx_instr_enc;
    logic [XLEN-1:0]         vtx_instr_rs1;
    logic [2:0]              vtx_instr_result;
    logic                    vtx_instr_wen;
    logic [4:0]              vtx_instr_waddr;
    logic [XLEN-1:0]         vtx_instr_wdata;
    logic [2:0]              vtx_mem_count;
    logic [MEM_HIST*XLEN-1:0] vtx_mem_addr, vtx_mem_rdata;
    logic [MEM_HIST-1:0]     vtx_mem_wen, vtx_mem_error;
    logic [2:0]              vtx_inflight;
    logic                    vtx_overflow, vtx_underflow;
`ifdef VTX_CPR_SNAPSHOT_EN
    logic [NREGS*XLEN-1:0]   vtx_cprs_pre, vtx_cprs_post;
`endif

    vtx_txn_capture #(
        .XLEN(XLEN), .NREGS(NREGS), .DEPTH(DEPTH), .MEM_HIST(MEM_HIST)
    ) dut (
        .g_clk(g_clk), .g_reset(g_reset),
        .cpu_insn_req(cpu_insn_req), .cop_insn_ack(cop_insn_ack),
        .cpu_insn_enc(cpu_insn_enc), .cpu_rs1(cpu_rs1),
        .cop_insn_rsp(cop_insn_rsp), .cpu_insn_ack(cpu_insn_ack),
        .cop_result(cop_result), .cop_wen(cop_wen), .cop_waddr(cop_waddr), .cop_wdata(cop_wdata),
        .cop_mem_cen(cop_mem_cen), .cop_mem_wen(cop_mem_wen), .cop_mem_stall(cop_mem_stall),
        .cop_mem_error(cop_mem_error), .cop_mem_addr(cop_mem_addr), .cop_mem_rdata(cop_mem_rdata),
        .cprs_snoop(cprs_snoop),
        .vtx_valid(vtx_valid), .vtx_instr_enc(vtx_instr_enc), .vtx_instr_rs1(vtx_instr_rs1),
        .vtx_instr_result(vtx_instr_result), .vtx_instr_wen(vtx_instr_wen),
        .vtx_instr_waddr(vtx_instr_waddr), .vtx_instr_wdata(vtx_instr_wdata),
        .vtx_mem_count(vtx_mem_count), .vtx_mem_addr(vtx_mem_addr), .vtx_mem_rdata(vtx_mem_rdata),
        .vtx_mem_wen(vtx_mem_wen), .vtx_mem_error(vtx_mem_error),
        .vtx_inflight(vtx_inflight), .vtx_overflow(vtx_overflow), .vtx_underflow(vtx_underflow)
`ifdef VTX_CPR_SNAPSHOT_EN
        , .vtx_cprs_pre(vtx_cprs_pre), .vtx_cprs_post(vtx_cprs_post)
`endif
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        rst, iss, ret;
        logic [31:0] enc, rs1, wdata;
        logic        ev;
        logic [31:0] eenc, ers1, ewdata;
        int          einfl;
        logic        eovf, eunf;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, iss, ret, input logic [31:0] enc, rs1, wdata,
                       input logic ev, input logic [31:0] eenc, ers1, ewdata,
                       input int einfl, input logic eovf, eunf);
        vec_t t;
        t.rst = rst; t.iss = iss; t.ret = ret; t.enc = enc; t.rs1 = rs1; t.wdata = wdata;
        t.ev = ev; t.eenc = eenc; t.ers1 = ers1; t.ewdata = ewdata;
        t.einfl = einfl; t.eovf = eovf; t.eunf = eunf;
        vq.push_back(t);
    endtask

    // Inputs are applied 1 time unit after an edge, sampled at the next edge,
    // and outputs are read 1 time unit after that edge.
    task automatic step(input logic rst, iss, ret, input logic [31:0] enc, rs1, wdata);
        g_reset      = rst;
        cpu_insn_req = iss;  cop_insn_ack = iss;
        cop_insn_rsp = ret;  cpu_insn_ack = ret;
        cpu_insn_enc = enc;  cpu_rs1 = rs1;  cop_wdata = wdata;
        @(posedge g_clk);
        #1;
    endtask

    task automatic mem(input logic cen, input logic [31:0] addr, input logic wen, stall,
                       input logic [31:0] rdata);
        cop_mem_cen = cen; cop_mem_addr = addr; cop_mem_wen = wen;
        cop_mem_stall = stall; cop_mem_rdata = rdata;
    endtask

    function automatic logic [31:0] ma(input int i);
        return vtx_mem_addr[i*XLEN +: XLEN];
    endfunction

    function automatic logic [31:0] md(input int i);
        return vtx_mem_rdata[i*XLEN +: XLEN];
    endfunction

    initial begin
        g_reset = 1'b1;
        cpu_insn_req = 0; cop_insn_ack = 0; cop_insn_rsp = 0; cpu_insn_ack = 0;
        cpu_insn_enc = '0; cpu_rs1 = '0;
        cop_result = VTX_RESULT_OK; cop_wen = 1'b1; cop_waddr = 5'd3; cop_wdata = '0;
        cop_mem_error = 1'b0;
        mem(0, 0, 0, 0, 0);
        cprs_snoop = '0;

        //   rst iss ret enc    rs1    wdata   ev eenc   ers1   ewdata  infl ovf unf
        add(1, 0, 0, 0,      0,     0,      0, 0,     0,     0,      0, 0, 0);
        add(0, 0, 0, 0,      0,     0,      0, 0,     0,     0,      0, 0, 0);
        add(0, 1, 0, 'h1234, 'hA5,  0,      0, 0,     0,     0,      1, 0, 0);
        for (int i = 0; i < 3; i++)
            add(0, 0, 0, 0,  0,     0,      0, 0,     0,     0,      1, 0, 0);
        add(0, 0, 1, 0,      0,     'h55,   1, 'h1234,'hA5,  'h55,   0, 0, 0);
        for (int i = 1; i <= 4; i++)
            add(0, 1, 0, i,  i*16,  0,      0, 0,     0,     0,      i, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            add(0, 0, 1, 0,  0,     'h100+i, 1, i,    i*16,  'h100+i, 4-i, 0, 0);
            if (i < 4)
                add(0, 0, 0, 0, 0,  0,      0, 0,     0,     0,      4-i, 0, 0);
        end
        for (int i = 5; i <= 8; i++)
            add(0, 1, 0, i,  i*16,  0,      0, 0,     0,     0,      i-4, 0, 0);
        add(0, 1, 1, 9,      'h90,  'h105,  1, 5,     'h50,  'h105,  4, 0, 0);
        add(0, 1, 0, 'hA,    'hA0,  0,      0, 0,     0,     0,      4, 1, 0);
        for (int i = 6; i <= 9; i++)
            add(0, 0, 1, 0,  0,     'h100+i, 1, i,    i*16,  'h100+i, 9-i, 1, 0);
        add(0, 0, 1, 0,      0,     0,      0, 0,     0,     0,      0, 1, 1);
        add(1, 0, 0, 0,      0,     0,      0, 0,     0,     0,      0, 0, 0);
        add(0, 1, 1, 'hB,    'hB0,  0,      0, 0,     0,     0,      1, 0, 1);
        add(0, 1, 0, 'hC,    'hC0,  0,      0, 0,     0,     0,      2, 0, 1);
        add(1, 0, 0, 0,      0,     0,      0, 0,     0,     0,      0, 0, 0);
        add(0, 0, 1, 0,      0,     0,      0, 0,     0,     0,      0, 0, 1);
        add(1, 0, 0, 0,      0,     0,      0, 0,     0,     0,      0, 0, 0);

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].rst, vq[i].iss, vq[i].ret, vq[i].enc, vq[i].rs1, vq[i].wdata);
            chk($sformatf("v%0d_valid", i), vtx_valid, vq[i].ev);
            if (vq[i].ev) begin
                chk($sformatf("v%0d_enc", i),   vtx_instr_enc,   vq[i].eenc);
                chk($sformatf("v%0d_rs1", i),   vtx_instr_rs1,   vq[i].ers1);
                chk($sformatf("v%0d_wdata", i), vtx_instr_wdata, vq[i].ewdata);
                chk($sformatf("v%0d_waddr", i), vtx_instr_waddr, 5'd3);
                chk($sformatf("v%0d_wen", i),   vtx_instr_wen,   1'b1);
                chk($sformatf("v%0d_mcnt", i),  vtx_mem_count,   0);
            end
            chk($sformatf("v%0d_inflight", i), vtx_inflight, vq[i].einfl);
            chk($sformatf("v%0d_ovf", i),      vtx_overflow,  vq[i].eovf);
            chk($sformatf("v%0d_unf", i),      vtx_underflow, vq[i].eunf);
        end

        // Three loads, the second response stalled for two cycles; the retire
        // cycle carries the last finish and a new start for the next instruction.
        step(0, 1, 0, 'h20, 'h200, 0);
        mem(1, 'h100, 0, 0, 0);        step(0, 1, 0, 'h21, 'h210, 0);
        mem(1, 'h104, 0, 0, 'hD100);   step(0, 0, 0, 0, 0, 0);
        mem(1, 'h108, 0, 1, 0);        step(0, 0, 0, 0, 0, 0);
        mem(1, 'h108, 0, 1, 0);        step(0, 0, 0, 0, 0, 0);
        mem(1, 'h108, 0, 0, 'hD104);   step(0, 0, 0, 0, 0, 0);
        mem(1, 'h200, 0, 0, 'hD108);
        cop_result = VTX_RESULT_FAIL;  step(0, 0, 1, 0, 0, 'h77);
        cop_result = VTX_RESULT_OK;
        chk("m1_valid",  vtx_valid, 1'b1);
        chk("m1_enc",    vtx_instr_enc, 'h20);
        chk("m1_result", vtx_instr_result, VTX_RESULT_FAIL);
        chk("m1_count",  vtx_mem_count, 3);
        chk("m1_addr0",  ma(0), 'h108);
        chk("m1_rdata0", md(0), 'hD108);
        chk("m1_addr1",  ma(1), 'h104);
        chk("m1_rdata1", md(1), 'hD104);
        chk("m1_addr2",  ma(2), 'h100);
        chk("m1_rdata2", md(2), 'hD100);
        chk("m1_wen",    vtx_mem_wen, 5'b00000);
        chk("m1_err",    vtx_mem_error, 5'b00000);
        chk("m1_infl",   vtx_inflight, 1);

        // Six back-to-back accesses 0x200..0x214, the fourth a store.
        mem(1, 'h204, 0, 0, 'hD200);   step(0, 0, 0, 0, 0, 0);
        chk("m2_pulse", vtx_valid, 1'b0);
        chk("m2_hold",  vtx_instr_enc, 'h20);
        mem(1, 'h208, 0, 0, 'hD204);   step(0, 0, 0, 0, 0, 0);
        mem(1, 'h20C, 1, 0, 'hD208);   step(0, 0, 0, 0, 0, 0);
        mem(1, 'h210, 0, 0, 'hD20C);   step(0, 0, 0, 0, 0, 0);
        mem(1, 'h214, 0, 0, 'hD210);   step(0, 0, 0, 0, 0, 0);
        mem(0, 0, 0, 0, 'hD214);       step(0, 0, 1, 0, 0, 'h88);
        mem(0, 0, 0, 0, 0);
        chk("m2_valid",  vtx_valid, 1'b1);
        chk("m2_enc",    vtx_instr_enc, 'h21);
        chk("m2_rs1",    vtx_instr_rs1, 'h210);
        chk("m2_count",  vtx_mem_count, 5);
        chk("m2_addr0",  ma(0), 'h214);
        chk("m2_rdata0", md(0), 'hD214);
        chk("m2_addr3",  ma(3), 'h208);
        chk("m2_rdata3", md(3), 'hD208);
        chk("m2_addr4",  ma(4), 'h204);
        chk("m2_rdata4", md(4), 'hD204);
        chk("m2_wen",    vtx_mem_wen, 5'b00100);
        chk("m2_infl",   vtx_inflight, 0);

`ifdef VTX_CPR_SNAPSHOT_EN
        step(1, 0, 0, 0, 0, 0);
        cprs_snoop[7*XLEN +: XLEN] = 'h11;
        step(0, 1, 0, 'h30, 0, 0);
        cprs_snoop[7*XLEN +: XLEN] = 'h22;
        step(0, 0, 1, 0, 0, 0);
        chk("cpr_valid", vtx_valid, 1'b1);
        chk("cpr_pre7",  vtx_cprs_pre[7*XLEN +: XLEN], 'h11);
        chk("cpr_post7", vtx_cprs_post[7*XLEN +: XLEN], 'h22);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
